// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch unit with 1-entry skid and redirect handling
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        pc_src,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic [31:0] pc_plus_4,
   output logic        inst_valid,
   output logic        if_flush
);

   typedef enum logic [1:0] {BOOT, FETCH, STALL} state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] instruction_n, pc_plus_4_n;
   logic        inst_valid_n;
   logic [31:0] skid_word, skid_word_n;
   logic [31:0] skid_pc4, skid_pc4_n;
   logic        skid_valid, skid_valid_n;
   logic [31:0] pend_target, pend_target_n;
   logic        pend_valid, pend_valid_n;
   logic [31:0] pc_inc;
   logic        consume;

   // IF/ID slot is taken downstream only when live, not stalled and not being flushed
   assign consume  = inst_valid & ~freeze & ~pc_src;
   assign pc_inc   = pc + 32'd4;
   assign if_flush = pc_src;

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= BOOT;
      else     state <= state_n;
   end

   // datapath registers: pc, IF/ID slot, skid entry and pending redirect
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc          <= RESET_PC;
         instruction <= 32'd0;
         pc_plus_4   <= 32'd0;
         inst_valid  <= 1'b0;
         skid_word   <= 32'd0;
         skid_pc4    <= 32'd0;
         skid_valid  <= 1'b0;
         pend_target <= 32'd0;
         pend_valid  <= 1'b0;
      end else begin
         pc          <= pc_n;
         instruction <= instruction_n;
         pc_plus_4   <= pc_plus_4_n;
         inst_valid  <= inst_valid_n;
         skid_word   <= skid_word_n;
         skid_pc4    <= skid_pc4_n;
         skid_valid  <= skid_valid_n;
         pend_target <= pend_target_n;
         pend_valid  <= pend_valid_n;
      end
   end

   // next-state and memory request decode; pc only moves on completion so imem_addr holds
   always_comb begin
      state_n       = state;
      pc_n          = pc;
      instruction_n = instruction;
      pc_plus_4_n   = pc_plus_4;
      inst_valid_n  = inst_valid;
      skid_word_n   = skid_word;
      skid_pc4_n    = skid_pc4;
      skid_valid_n  = skid_valid;
      pend_target_n = pend_target;
      pend_valid_n  = pend_valid;
      imem_req      = 1'b0;
      imem_addr     = pc;
      case (state)
         BOOT: begin
            state_n = FETCH;
            if (pc_src) begin
               pc_n         = branch_target;
               skid_valid_n = 1'b0;
               inst_valid_n = 1'b0;
               pend_valid_n = 1'b0;
            end
         end
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               if (pc_src || pend_valid) begin
                  // the returning word belongs to the wrong path and is dropped
                  pc_n         = pc_src ? branch_target : pend_target;
                  pend_valid_n = 1'b0;
                  inst_valid_n = 1'b0;
               end else if (!inst_valid || consume) begin
                  instruction_n = imem_rdata;
                  pc_plus_4_n   = pc_inc;
                  inst_valid_n  = 1'b1;
                  pc_n          = pc_inc;
               end else begin
                  skid_word_n  = imem_rdata;
                  skid_pc4_n   = pc_inc;
                  skid_valid_n = 1'b1;
                  pc_n         = pc_inc;
                  state_n      = STALL;
               end
            end else if (pc_src) begin
               // request in flight: remember the target until the memory completes
               pend_valid_n  = 1'b1;
               pend_target_n = branch_target;
               inst_valid_n  = 1'b0;
            end else if (consume) begin
               inst_valid_n = 1'b0;
            end
         end
         STALL: begin
            if (pc_src) begin
               pc_n         = branch_target;
               skid_valid_n = 1'b0;
               inst_valid_n = 1'b0;
               state_n      = FETCH;
            end else if (consume) begin
               instruction_n = skid_word;
               pc_plus_4_n   = skid_pc4;
               inst_valid_n  = skid_valid;
               skid_valid_n  = 1'b0;
               state_n       = FETCH;
            end
         end
         default: state_n = BOOT;
      endcase
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard testbench for if_fetch_unit
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        freeze = 1'b0;
   logic        pc_src = 1'b0;
   logic [31:0] branch_target = 32'd0;
   logic        imem_ready = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        imem_req, inst_valid, if_flush;
   logic [31:0] imem_addr, instruction, pc_plus_4;
   logic        w_req, w_valid, w_flush;
   logic [31:0] w_addr, w_instr, w_pc4;

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc4;
   } exp_t;
   exp_t sb[$];

   int n_tests = 0;
   int n_fail  = 0;
   bit sb_en   = 1'b1;

   if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .freeze(freeze), .pc_src(pc_src), .branch_target(branch_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instruction(instruction), .pc_plus_4(pc_plus_4), .inst_valid(inst_valid), .if_flush(if_flush)
   );

   if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .rst(rst), .freeze(freeze), .pc_src(pc_src), .branch_target(branch_target),
      .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
      .instruction(w_instr), .pc_plus_4(w_pc4), .inst_valid(w_valid), .if_flush(w_flush)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   function automatic logic [31:0] word(input logic [31:0] a);
      return {a[15:0] ^ 16'h1357, a[15:0]};
   endfunction

   // scoreboard: every consume edge must deliver the oldest expected instruction
   always @(negedge clk) begin
      #2;
      if (sb_en && !rst && inst_valid && !freeze && !pc_src) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected got ins=%h pc4=%h exp none", instruction, pc_plus_4);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (instruction !== e.ins || pc_plus_4 !== e.pc4) begin
               n_fail++;
               $display("FAIL sb_data got ins=%h pc4=%h exp ins=%h pc4=%h", instruction, pc_plus_4, e.ins, e.pc4);
            end
         end
      end
   end

   task automatic step(input logic fz, input logic ps, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] rd);
      @(negedge clk);
      freeze = fz; pc_src = ps; branch_target = tgt; imem_ready = rdy; imem_rdata = rd;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; freeze = 1'b0; pc_src = 1'b0; branch_target = 32'd0;
      imem_ready = 1'b0; imem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      n_tests++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || instruction !== 32'd0 || pc_plus_4 !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got req=%b v=%b ins=%h pc4=%h exp 0 0 0 0", imem_req, inst_valid, instruction, pc_plus_4);
      end
      do_reset();
      step(0, 0, 0, 0, 0);
      n_tests++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_boot_req got %b exp 0", imem_req); end
      step(0, 0, 0, 0, 0);
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         n_fail++; $display("FAIL reset_first_req got req=%b addr=%h exp 1 00000000", imem_req, imem_addr);
      end
   endtask

   task automatic test_throughput();
      logic [31:0] a;
      do_reset();
      step(0, 0, 0, 1, 32'hFFFF_FFFF);
      n_tests++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL tput_boot got req=%b exp 0", imem_req); end
      for (int i = 0; i < 5; i++) begin
         a = 32'(i) * 32'd4;
         step(0, 0, 0, 1, word(a));
         n_tests++;
         if (imem_req !== 1'b1 || imem_addr !== a) begin
            n_fail++; $display("FAIL tput_addr got req=%b addr=%h exp 1 %h", imem_req, imem_addr, a);
         end
         if (i > 0) begin
            n_tests++;
            if (inst_valid !== 1'b1 || pc_plus_4 !== a) begin
               n_fail++; $display("FAIL tput_valid got v=%b pc4=%h exp 1 %h", inst_valid, pc_plus_4, a);
            end
         end
         sb.push_back('{ins: word(a), pc4: a + 32'd4});
      end
      step(0, 0, 0, 0, 0);
      n_tests++;
      if (inst_valid !== 1'b1 || pc_plus_4 !== 32'd20) begin
         n_fail++; $display("FAIL tput_last got v=%b pc4=%h exp 1 00000014", inst_valid, pc_plus_4);
      end
      step(0, 0, 0, 0, 0);
      n_tests++;
      if (inst_valid !== 1'b0 || imem_addr !== 32'd20) begin
         n_fail++; $display("FAIL tput_drain got v=%b addr=%h exp 0 00000014", inst_valid, imem_addr);
      end
      n_tests++;
      if (sb.size() != 0) begin n_fail++; $display("FAIL tput_sb_left got %0d exp 0", sb.size()); end
   endtask

   task automatic test_wait();
      do_reset();
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 32'hBAD0_0000);
         n_tests++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
            n_fail++; $display("FAIL wait_hold got req=%b addr=%h v=%b exp 1 00000000 0", imem_req, imem_addr, inst_valid);
         end
      end
      step(0, 0, 0, 1, word(32'h0));
      n_tests++;
      if (imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
         n_fail++; $display("FAIL wait_ready got addr=%h v=%b exp 00000000 0", imem_addr, inst_valid);
      end
      sb.push_back('{ins: word(32'h0), pc4: 32'h4});
      step(0, 0, 0, 0, 0);
      n_tests++;
      if (inst_valid !== 1'b1 || imem_addr !== 32'h4) begin
         n_fail++; $display("FAIL wait_valid got v=%b addr=%h exp 1 00000004", inst_valid, imem_addr);
      end
      step(0, 0, 0, 0, 0);
      n_tests++;
      if (inst_valid !== 1'b0 || sb.size() != 0) begin
         n_fail++; $display("FAIL wait_drain got v=%b left=%0d exp 0 0", inst_valid, sb.size());
      end
   endtask

   task automatic test_freeze();
      do_reset();
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, word(32'h0));
      sb.push_back('{ins: word(32'h0), pc4: 32'h4});
      step(1, 0, 0, 1, 32'h2002_0005);
      n_tests++;
      if (imem_addr !== 32'h4 || inst_valid !== 1'b1) begin
         n_fail++; $display("FAIL frz_skid_cycle got addr=%h v=%b exp 00000004 1", imem_addr, inst_valid);
      end
      sb.push_back('{ins: 32'h2002_0005, pc4: 32'h8});
      step(1, 0, 0, 1, 32'hDEAD_0000);
      n_tests++;
      if (imem_req !== 1'b0 || instruction !== word(32'h0)) begin
         n_fail++; $display("FAIL frz_stall got req=%b ins=%h exp 0 %h", imem_req, instruction, word(32'h0));
      end
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      n_tests++;
      if (instruction !== 32'h2002_0005 || pc_plus_4 !== 32'h8 || imem_req !== 1'b1 || imem_addr !== 32'h8) begin
         n_fail++; $display("FAIL frz_release got ins=%h pc4=%h req=%b addr=%h exp 20020005 00000008 1 00000008",
                            instruction, pc_plus_4, imem_req, imem_addr);
      end
      step(0, 0, 0, 0, 0);
      n_tests++;
      if (inst_valid !== 1'b0 || sb.size() != 0) begin
         n_fail++; $display("FAIL frz_drain got v=%b left=%0d exp 0 0", inst_valid, sb.size());
      end
   endtask

   task automatic test_redirect();
      do_reset();
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, word(32'h0));
      sb.push_back('{ins: word(32'h0), pc4: 32'h4});
      step(0, 0, 0, 1, word(32'h4));
      sb.push_back('{ins: word(32'h4), pc4: 32'h8});
      step(0, 1, 32'h100, 0, 0);
      n_tests++;
      if (if_flush !== 1'b1 || imem_addr !== 32'h8) begin
         n_fail++; $display("FAIL redir_flush got flush=%b addr=%h exp 1 00000008", if_flush, imem_addr);
      end
      sb.delete();
      step(0, 0, 32'h0, 0, 0);
      n_tests++;
      if (if_flush !== 1'b0 || imem_addr !== 32'h8 || inst_valid !== 1'b0) begin
         n_fail++; $display("FAIL redir_hold got flush=%b addr=%h v=%b exp 0 00000008 0", if_flush, imem_addr, inst_valid);
      end
      step(0, 0, 0, 1, 32'hDEAD_BEEF);
      n_tests++;
      if (imem_addr !== 32'h8 || inst_valid !== 1'b0) begin
         n_fail++; $display("FAIL redir_drop_cycle got addr=%h v=%b exp 00000008 0", imem_addr, inst_valid);
      end
      step(0, 0, 0, 0, 0);
      n_tests++;
      if (imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
         n_fail++; $display("FAIL redir_target got addr=%h v=%b exp 00000100 0", imem_addr, inst_valid);
      end
      step(0, 0, 0, 1, word(32'h100));
      sb.push_back('{ins: word(32'h100), pc4: 32'h104});
      step(0, 0, 0, 0, 0);
      n_tests++;
      if (inst_valid !== 1'b1 || pc_plus_4 !== 32'h104) begin
         n_fail++; $display("FAIL redir_new_path got v=%b pc4=%h exp 1 00000104", inst_valid, pc_plus_4);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      sb_en = 1'b0;
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 32'h1111_2222);
      n_tests++;
      if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
         n_fail++; $display("FAIL wrap_first got req=%b addr=%h exp 1 fffffffc", w_req, w_addr);
      end
      step(0, 0, 0, 1, 32'h3333_4444);
      n_tests++;
      if (w_addr !== 32'h0 || w_valid !== 1'b1 || w_pc4 !== 32'h0 || w_instr !== 32'h1111_2222) begin
         n_fail++; $display("FAIL wrap_second got addr=%h v=%b pc4=%h ins=%h exp 00000000 1 00000000 11112222",
                            w_addr, w_valid, w_pc4, w_instr);
      end
      do_reset();
      sb_en = 1'b1;
   endtask

   task automatic test_reset_stall();
      do_reset();
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, word(32'h0));
      step(1, 0, 0, 1, word(32'h4));
      step(1, 0, 0, 0, 0);
      n_tests++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin
         n_fail++; $display("FAIL rs_in_stall got req=%b v=%b exp 0 1", imem_req, inst_valid);
      end
      @(posedge clk);
      #2 rst = 1'b1; freeze = 1'b0;
      #1;
      n_tests++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || instruction !== 32'd0 || pc_plus_4 !== 32'd0) begin
         n_fail++; $display("FAIL rs_async got req=%b v=%b ins=%h pc4=%h exp 0 0 0 0", imem_req, inst_valid, instruction, pc_plus_4);
      end
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      sb.delete();
      step(0, 0, 0, 0, 0);
      n_tests++;
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rs_boot got req=%b exp 0", imem_req); end
      step(0, 0, 0, 0, 0);
      n_tests++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || inst_valid !== 1'b0) begin
         n_fail++; $display("FAIL rs_restart got req=%b addr=%h v=%b exp 1 00000000 0", imem_req, imem_addr, inst_valid);
      end
   endtask

   initial begin
      test_reset();
      test_throughput();
      test_wait();
      test_freeze();
      test_redirect();
      test_wrap();
      test_reset_stall();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
